target_tracker: RTL and testbench

Per-frame marker tracker that takes the row-level detections produced by the flip-counting stage and groups them into up to NUM_TARGETS targets. For each target it keeps the lowest-probability (best) row, the vertical extent, a row count and a proximity track. On every frame boundary it publishes a stable result set, then clears its working set for the next frame. It sits between the row detector and the overlay/position logic. It replaces free-running single-row target capture with per-frame commit, gap-based track closure, minimum-row qualification and overflow reporting.

---
 rtl/target_tracker.sv | 200 ++++++++++++++++++++
 tb/tb_target_tracker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/target_tracker.sv
// Groups row-level marker detections into up to NUM_TARGETS targets per frame
// and publishes a stable, qualified result set on every vsync rising edge.
module target_tracker #(
    parameter int NUM_TARGETS   = 4,
    parameter int SCREEN_WIDTH  = 1280,
    parameter int SCREEN_HEIGHT = 720,
    parameter int PROB_BITS     = 11,
    parameter int MIN_ROWS      = 2,
    parameter int GAP_ROWS      = 4,
    parameter int MERGE_SHIFT   = 1,
    localparam int XW = $clog2(SCREEN_WIDTH),
    localparam int YW = $clog2(SCREEN_HEIGHT) + 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        vsync_in,
    input  logic                        det_valid_in,
    input  logic [XW-1:0]               det_x_in,
    input  logic [YW-1:0]               det_y_in,
    input  logic [YW-1:0]               det_width_in,
    input  logic [PROB_BITS-1:0]        det_prob_in,
    output logic [NUM_TARGETS*XW-1:0]   xcount_out,
    output logic [NUM_TARGETS*YW-1:0]   ycount_out,
    output logic [NUM_TARGETS*YW-1:0]   diameter_out,
    output logic [NUM_TARGETS*YW-1:0]   span_out,
    output logic [NUM_TARGETS-1:0]      valid_out,
    output logic                        frame_done_out,
    output logic                        overflow_out
);

    localparam int DW = ((XW > YW) ? XW : YW) + 2;
    localparam int TW = DW + MERGE_SHIFT;

    logic                 vsync_q;
    logic                 frameDone_q;
    logic                 ovfWork_q;
    logic                 overflow_q;
    logic [NUM_TARGETS*XW-1:0] xcount_q;
    logic [NUM_TARGETS*YW-1:0] ycount_q;
    logic [NUM_TARGETS*YW-1:0] diameter_q;
    logic [NUM_TARGETS*YW-1:0] span_q;
    logic [NUM_TARGETS-1:0]    valid_q;

    logic                 used_q     [NUM_TARGETS];
    logic [XW-1:0]        bestX_q    [NUM_TARGETS];
    logic [YW-1:0]        bestY_q    [NUM_TARGETS];
    logic [YW-1:0]        bestW_q    [NUM_TARGETS];
    logic [PROB_BITS-1:0] bestP_q    [NUM_TARGETS];
    logic [YW-1:0]        yTop_q     [NUM_TARGETS];
    logic [YW-1:0]        yBot_q     [NUM_TARGETS];
    logic [XW-1:0]        trackX_q   [NUM_TARGETS];
    logic [YW-1:0]        trackY_q   [NUM_TARGETS];
    logic [YW-1:0]        trackW_q   [NUM_TARGETS];
    logic [YW-1:0]        rowCount_q [NUM_TARGETS];

    logic                   frameEdge;
    logic [NUM_TARGETS-1:0] matchVec;
    logic [NUM_TARGETS-1:0] qualVec;
    logic [NUM_TARGETS-1:0] updSel;
    logic [NUM_TARGETS-1:0] allocSel;
    logic                   anyMatch;
    logic                   anyFree;
    logic [YW-1:0]          spanW [NUM_TARGETS];

    assign frameEdge = vsync_in & ~vsync_q;

    // Per-slot proximity test against the last accepted row of each track.
    for (genvar s = 0; s < NUM_TARGETS; s++) begin : g_slot
        logic [DW-1:0] detXe, detYe, trkXe, trkYe, dx, dy;
        logic [TW-1:0] thr;
        assign detXe = DW'(det_x_in);
        assign detYe = DW'(det_y_in);
        assign trkXe = DW'(trackX_q[s]);
        assign trkYe = DW'(trackY_q[s]);
        assign dx    = (detXe >= trkXe) ? (detXe - trkXe) : (trkXe - detXe);
        assign dy    = detYe - trkYe;
        assign thr   = TW'(trackW_q[s]) << MERGE_SHIFT;
        assign matchVec[s] = used_q[s] && (det_y_in >= trackY_q[s]) &&
                             (dy <= DW'(GAP_ROWS)) && (TW'(dx + dy) <= thr);
        assign qualVec[s]  = used_q[s] && (rowCount_q[s] >= YW'(MIN_ROWS));
        assign spanW[s]    = yBot_q[s] - yTop_q[s] + YW'(1);
    end

    // Lowest index wins for both track update and allocation.
    always_comb begin
        updSel   = '0;
        allocSel = '0;
        anyMatch = 1'b0;
        anyFree  = 1'b0;
        for (int s = 0; s < NUM_TARGETS; s++) begin
            if (matchVec[s] && !anyMatch) begin
                updSel[s] = 1'b1;
                anyMatch  = 1'b1;
            end
            if (!used_q[s] && !anyFree) begin
                allocSel[s] = 1'b1;
                anyFree     = 1'b1;
            end
        end
        if (anyMatch) begin
            allocSel = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vsync_q     <= 1'b0;
            frameDone_q <= 1'b0;
            ovfWork_q   <= 1'b0;
            overflow_q  <= 1'b0;
            xcount_q    <= '0;
            ycount_q    <= '0;
            diameter_q  <= '0;
            span_q      <= '0;
            valid_q     <= '0;
            for (int s = 0; s < NUM_TARGETS; s++) begin
                used_q[s]     <= 1'b0;
                bestX_q[s]    <= '0;
                bestY_q[s]    <= '0;
                bestW_q[s]    <= '0;
                bestP_q[s]    <= '0;
                yTop_q[s]     <= '0;
                yBot_q[s]     <= '0;
                trackX_q[s]   <= '0;
                trackY_q[s]   <= '0;
                trackW_q[s]   <= '0;
                rowCount_q[s] <= '0;
            end
        end else begin
            vsync_q     <= vsync_in;
            frameDone_q <= frameEdge;
            if (frameEdge) begin
                // Publish the finished frame and start the next one empty.
                overflow_q <= ovfWork_q;
                ovfWork_q  <= 1'b0;
                for (int s = 0; s < NUM_TARGETS; s++) begin
                    valid_q[s]             <= qualVec[s];
                    xcount_q[s*XW +: XW]   <= qualVec[s] ? bestX_q[s] : '0;
                    ycount_q[s*YW +: YW]   <= qualVec[s] ? bestY_q[s] : '0;
                    diameter_q[s*YW +: YW] <= qualVec[s] ? bestW_q[s] : '0;
                    span_q[s*YW +: YW]     <= qualVec[s] ? spanW[s]   : '0;
                    used_q[s]     <= 1'b0;
                    bestX_q[s]    <= '0;
                    bestY_q[s]    <= '0;
                    bestW_q[s]    <= '0;
                    bestP_q[s]    <= '0;
                    yTop_q[s]     <= '0;
                    yBot_q[s]     <= '0;
                    trackX_q[s]   <= '0;
                    trackY_q[s]   <= '0;
                    trackW_q[s]   <= '0;
                    rowCount_q[s] <= '0;
                end
            end else if (det_valid_in) begin
                if (!anyMatch && !anyFree) begin
                    ovfWork_q <= 1'b1;
                end
                for (int s = 0; s < NUM_TARGETS; s++) begin
                    if (updSel[s]) begin
                        trackX_q[s] <= det_x_in;
                        trackY_q[s] <= det_y_in;
                        trackW_q[s] <= det_width_in;
                        yBot_q[s]   <= det_y_in;
                        if (rowCount_q[s] != '1) begin
                            rowCount_q[s] <= rowCount_q[s] + YW'(1);
                        end
                        // Strict compare keeps the earlier row on a probability tie.
                        if (det_prob_in < bestP_q[s]) begin
                            bestX_q[s] <= det_x_in;
                            bestY_q[s] <= det_y_in;
                            bestW_q[s] <= det_width_in;
                            bestP_q[s] <= det_prob_in;
                        end
                    end else if (allocSel[s]) begin
                        used_q[s]     <= 1'b1;
                        bestX_q[s]    <= det_x_in;
                        bestY_q[s]    <= det_y_in;
                        bestW_q[s]    <= det_width_in;
                        bestP_q[s]    <= det_prob_in;
                        yTop_q[s]     <= det_y_in;
                        yBot_q[s]     <= det_y_in;
                        trackX_q[s]   <= det_x_in;
                        trackY_q[s]   <= det_y_in;
                        trackW_q[s]   <= det_width_in;
                        rowCount_q[s] <= YW'(1);
                    end
                end
            end
        end
    end

    assign xcount_out     = xcount_q;
    assign ycount_out     = ycount_q;
    assign diameter_out   = diameter_q;
    assign span_out       = span_q;
    assign valid_out      = valid_q;
    assign frame_done_out = frameDone_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_target_tracker.sv
// Directed and randomized bench for target_tracker, checked every cycle against
// a frame-level reference model built from the grouping rules.
module tb_target_tracker;

    localparam int NT   = 4;
    localparam int SW   = 1280;
    localparam int SH   = 720;
    localparam int PB   = 11;
    localparam int MINR = 2;
    localparam int GAP  = 4;
    localparam int MS   = 1;
    localparam int XW   = $clog2(SW);
    localparam int YW   = $clog2(SH) + 1;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              vsync_in;
    logic              det_valid_in;
    logic [XW-1:0]     det_x_in;
    logic [YW-1:0]     det_y_in;
    logic [YW-1:0]     det_width_in;
    logic [PB-1:0]     det_prob_in;
    logic [NT*XW-1:0]  xcount_out;
    logic [NT*YW-1:0]  ycount_out;
    logic [NT*YW-1:0]  diameter_out;
    logic [NT*YW-1:0]  span_out;
    logic [NT-1:0]     valid_out;
    logic              frame_done_out;
    logic              overflow_out;

    int checks = 0;
    int errors = 0;

    // Reference model: working slots and the currently published result set.
    int mUsed[NT], mBx[NT], mBy[NT], mBw[NT], mBp[NT];
    int mTop[NT], mBot[NT], mTx[NT], mTy[NT], mTw[NT], mCnt[NT];
    int mOvf, mVsPrev;
    int eX[NT], eY[NT], eD[NT], eS[NT], eV[NT];
    int eDone, eOvf;

    always #5 clk_in = ~clk_in;

    target_tracker #(
        .NUM_TARGETS(NT), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .PROB_BITS(PB),
        .MIN_ROWS(MINR), .GAP_ROWS(GAP), .MERGE_SHIFT(MS)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .vsync_in(vsync_in),
        .det_valid_in(det_valid_in), .det_x_in(det_x_in), .det_y_in(det_y_in),
        .det_width_in(det_width_in), .det_prob_in(det_prob_in),
        .xcount_out(xcount_out), .ycount_out(ycount_out), .diameter_out(diameter_out),
        .span_out(span_out), .valid_out(valid_out), .frame_done_out(frame_done_out),
        .overflow_out(overflow_out)
    );

    task automatic clearSlot(input int s);
        mUsed[s] = 0; mBx[s] = 0; mBy[s] = 0; mBw[s] = 0; mBp[s] = 0;
        mTop[s] = 0; mBot[s] = 0; mTx[s] = 0; mTy[s] = 0; mTw[s] = 0; mCnt[s] = 0;
    endtask

    task automatic modelReset();
        for (int s = 0; s < NT; s++) begin
            clearSlot(s);
            eX[s] = 0; eY[s] = 0; eD[s] = 0; eS[s] = 0; eV[s] = 0;
        end
        mOvf = 0; mVsPrev = 0; eDone = 0; eOvf = 0;
    endtask

    task automatic modelDetect(input int x, input int y, input int w, input int p);
        int hit, freeSlot, dx, dy;
        hit = -1;
        freeSlot = -1;
        for (int s = 0; s < NT; s++) begin
            dy = y - mTy[s];
            dx = (x > mTx[s]) ? x - mTx[s] : mTx[s] - x;
            if (hit < 0 && mUsed[s] != 0 && dy >= 0 && dy <= GAP &&
                dx + dy <= (mTw[s] << MS))
                hit = s;
            if (freeSlot < 0 && mUsed[s] == 0)
                freeSlot = s;
        end
        if (hit >= 0) begin
            mTx[hit] = x; mTy[hit] = y; mTw[hit] = w; mBot[hit] = y;
            if (mCnt[hit] < (1 << YW) - 1) mCnt[hit]++;
            if (p < mBp[hit]) begin
                mBx[hit] = x; mBy[hit] = y; mBw[hit] = w; mBp[hit] = p;
            end
        end else if (freeSlot >= 0) begin
            mUsed[freeSlot] = 1;
            mBx[freeSlot] = x; mBy[freeSlot] = y; mBw[freeSlot] = w; mBp[freeSlot] = p;
            mTx[freeSlot] = x; mTy[freeSlot] = y; mTw[freeSlot] = w;
            mTop[freeSlot] = y; mBot[freeSlot] = y; mCnt[freeSlot] = 1;
        end else begin
            mOvf = 1;
        end
    endtask

    task automatic modelClock(input int v, input int x, input int y, input int w,
                              input int p, input int vs);
        bit edgeNow;
        bit q;
        edgeNow = (vs != 0) && (mVsPrev == 0);
        mVsPrev = vs;
        eDone = edgeNow ? 1 : 0;
        if (edgeNow) begin
            for (int s = 0; s < NT; s++) begin
                q = (mUsed[s] != 0) && (mCnt[s] >= MINR);
                eV[s] = q ? 1 : 0;
                eX[s] = q ? mBx[s] : 0;
                eY[s] = q ? mBy[s] : 0;
                eD[s] = q ? mBw[s] : 0;
                eS[s] = q ? ((mBot[s] - mTop[s] + 1) & ((1 << YW) - 1)) : 0;
                clearSlot(s);
            end
            eOvf = mOvf;
            mOvf = 0;
        end else if (v != 0) begin
            modelDetect(x, y, w, p);
        end
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [63:0] ex, ey, ed, es, ev;
        ex = '0; ey = '0; ed = '0; es = '0; ev = '0;
        for (int s = 0; s < NT; s++) begin
            ex[s*XW +: XW] = XW'(eX[s]);
            ey[s*YW +: YW] = YW'(eY[s]);
            ed[s*YW +: YW] = YW'(eD[s]);
            es[s*YW +: YW] = YW'(eS[s]);
            ev[s]          = eV[s][0];
        end
        cmp({tag, ".xcount"},   64'(xcount_out),     ex);
        cmp({tag, ".ycount"},   64'(ycount_out),     ey);
        cmp({tag, ".diameter"}, 64'(diameter_out),   ed);
        cmp({tag, ".span"},     64'(span_out),       es);
        cmp({tag, ".valid"},    64'(valid_out),      ev);
        cmp({tag, ".done"},     64'(frame_done_out), 64'(eDone));
        cmp({tag, ".overflow"}, 64'(overflow_out),   64'(eOvf));
    endtask

    task automatic applyStimulus(input string tag, input int v, input int x, input int y,
                                 input int w, input int p, input int vs);
        det_valid_in = v[0];
        det_x_in     = XW'(x);
        det_y_in     = YW'(y);
        det_width_in = YW'(w);
        det_prob_in  = PB'(p);
        vsync_in     = vs[0];
        modelClock(v, x, y, w, p, vs);
        @(negedge clk_in);
        checkOutput(tag);
    endtask

    task automatic frameEdge(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 1);
        applyStimulus({tag, ".held"}, 0, 0, 0, 0, 0, 1);
        applyStimulus({tag, ".low"}, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cx[6], cy[6];
        int nt, len, t, x, p;
        rst_in = 1'b1; vsync_in = 1'b0; det_valid_in = 1'b0;
        det_x_in = '0; det_y_in = '0; det_width_in = '0; det_prob_in = '0;
        modelReset();
        @(negedge clk_in);
        checkOutput("reset");
        rst_in = 1'b0;

        frameEdge("emptyFirst");

        applyStimulus("t1a", 1, 100, 50, 10, 300, 0);
        applyStimulus("t1b", 1, 100, 51, 10, 200, 0);
        applyStimulus("t1c", 1, 100, 52, 10, 250, 0);
        applyStimulus("t1edge", 0, 0, 0, 0, 0, 1);
        cmp("t1.slot0y", 64'(ycount_out[YW-1:0]), 64'd51);
        cmp("t1.slot0span", 64'(span_out[YW-1:0]), 64'd3);
        cmp("t1.validVec", 64'(valid_out), 64'b0001);
        applyStimulus("t1held", 0, 0, 0, 0, 0, 1);
        applyStimulus("t1low", 0, 0, 0, 0, 0, 0);

        applyStimulus("t2a", 1, 600, 200, 10, 100, 0);
        applyStimulus("t2b", 1, 300, 400, 8, 50, 0);
        applyStimulus("t2c", 1, 301, 401, 8, 60, 0);
        frameEdge("t2edge");

        applyStimulus("t3a", 1, 500, 10, 6, 100, 0);
        applyStimulus("t3b", 1, 500, 16, 6, 100, 0);
        frameEdge("t3edge");

        for (int i = 0; i < 5; i++)
            applyStimulus("t4det", 1, 100 + 200 * i, 100, 5, 10, 0);
        applyStimulus("t4edge", 0, 0, 0, 0, 0, 1);
        cmp("t4.overflow", 64'(overflow_out), 64'd1);
        applyStimulus("t4low", 0, 0, 0, 0, 0, 0);
        applyStimulus("t4clean", 1, 400, 300, 5, 10, 0);
        frameEdge("t4cleanEdge");

        applyStimulus("t5pre", 1, 700, 599, 10, 9, 0);
        applyStimulus("t5onEdge", 1, 700, 600, 10, 5, 1);
        applyStimulus("t5low", 0, 0, 0, 0, 0, 0);
        applyStimulus("t5post", 1, 700, 601, 10, 7, 0);
        frameEdge("t5edge");

        applyStimulus("t6a", 1, 400, 300, 10, 20, 0);
        applyStimulus("t6b", 1, 401, 301, 10, 10, 0);
        frameEdge("t6pub");
        applyStimulus("t6c", 1, 100, 500, 10, 20, 0);
        applyStimulus("t6d", 1, 900, 500, 10, 20, 0);
        #2;
        rst_in = 1'b1;
        modelReset();
        #1;
        checkOutput("t6asyncReset");
        @(negedge clk_in);
        checkOutput("t6resetHeld");
        rst_in = 1'b0;
        frameEdge("t6afterReset");

        for (int f = 0; f < 30; f++) begin
            nt = $urandom_range(1, 6);
            for (int i = 0; i < 6; i++) begin
                cx[i] = $urandom_range(20, 1250);
                cy[i] = $urandom_range(0, 500);
            end
            len = $urandom_range(20, 50);
            for (int c = 0; c < len; c++) begin
                t = $urandom_range(0, nt - 1);
                x = cx[t] + $urandom_range(0, 6) - 3;
                p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2047);
                applyStimulus("rand", ($urandom_range(0, 2) != 0) ? 1 : 0, x, cy[t],
                              $urandom_range(2, 20), p, 0);
                if ($urandom_range(0, 7) == 0) cy[t] += $urandom_range(3, 7);
                else cy[t] += $urandom_range(0, 1);
                if (cy[t] > 710) cy[t] = 710;
            end
            len = $urandom_range(1, 3);
            for (int c = 0; c < len; c++)
                applyStimulus("randEdge", $urandom_range(0, 1), cx[0], cy[0], 8, 100, 1);
            applyStimulus("randLow", 0, 0, 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
